arbitro_calculo: RTL and testbench

- Shares one polynomial datapath (operative block plus its sequencing controller) between N_REQ requesters.
- Arbitrates requests round-robin, loads the winner's operand, and pulses the controller's start (inicio).
- Waits for pronto, captures the result, returns it to the winner, then pulses the controller's reset so it is ready for the next run.
- Sits between the requesting units and the controller/datapath pair.

---
 rtl/arbitro_pkg.sv | 32 +++
 rtl/arbitro_rr_seletor.sv | 32 +++
 rtl/arbitro_calculo.sv | 122 ++++++++++++
 tb/tb_arbitro_calculo.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the polynomial datapath.
package arbitro_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    INICIA  = 2'd1,
    ESPERA  = 2'd2,
    ENTREGA = 2'd3
  } estado_t;

  // One-hot winner: first set bit scanning upward from (ultimo+1) mod n, wrapping around.
  // Vectors are sized for the largest supported requester count (8).
  function automatic logic [7:0] rr_onehot(input logic [7:0] req,
                                           input logic [2:0] ultimo,
                                           input int         n);
    logic [7:0] win;
    logic [2:0] pos;
    win = '0;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        pos = 3'((int'(ultimo) + k) % n);
        if (req[pos]) win = 8'(1) << pos;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/arbitro_rr_seletor.sv
// Combinational round-robin selector: picks the next requester after the last owner.
module arbitro_rr_seletor
  import arbitro_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ultimo,
  output logic [$clog2(N_REQ)-1:0] vencedor_idx,
  output logic [N_REQ-1:0]         vencedor,
  output logic                     valido
);

  localparam int IW = $clog2(N_REQ);

  logic [7:0] req_ext;
  logic [7:0] win_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    win_ext              = rr_onehot(req_ext, 3'(ultimo), N_REQ);
    vencedor             = win_ext[N_REQ-1:0];
    vencedor_idx         = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_ext[i]) vencedor_idx = IW'(i);
    end
  end

  assign valido = |req;

endmodule

// File: rtl/arbitro_calculo.sv
// Shares one polynomial controller/datapath between N_REQ requesters: round-robin grant,
// operand load, start pulse, bounded wait for pronto, result return and controller reset.
module arbitro_calculo
  import arbitro_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] op_x,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       result_out,
  output logic                    erro,
  output logic [DATA_W-1:0]       x_out,
  output logic                    inicio,
  input  logic                    pronto,
  input  logic [DATA_W-1:0]       result_in,
  output logic                    rst_ctrl,
  output logic                    busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  estado_t           estado, prox_estado;
  logic [IW-1:0]     ultimo;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     venc_idx;
  logic [N_REQ-1:0]  venc_oh;
  logic              venc_ok;
  logic [DATA_W-1:0] op_venc;
  logic [CW-1:0]     cnt;
  logic              expirou;

  arbitro_rr_seletor #(.N_REQ(N_REQ)) u_seletor (
    .req          (req),
    .ultimo       (ultimo),
    .vencedor_idx (venc_idx),
    .vencedor     (venc_oh),
    .valido       (venc_ok)
  );

  always_comb begin
    op_venc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (venc_oh[i]) op_venc = op_x[i*DATA_W +: DATA_W];
    end
  end

  // The last ESPERA cycle is the one whose count is TIMEOUT-1; pronto still wins there.
  assign expirou = (estado == ESPERA) && !pronto && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    prox_estado = estado;
    unique case (estado)
      OCIOSO:  if (venc_ok) prox_estado = INICIA;
      INICIA:  prox_estado = ESPERA;
      ESPERA:  if (pronto || expirou) prox_estado = ENTREGA;
      ENTREGA: prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado     <= OCIOSO;
      grant      <= '0;
      done       <= '0;
      result_out <= '0;
      erro       <= 1'b0;
      x_out      <= '0;
      inicio     <= 1'b0;
      rst_ctrl   <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      ultimo     <= IW'(N_REQ - 1);
      idx        <= '0;
    end else begin
      estado   <= prox_estado;
      busy     <= (prox_estado != OCIOSO);
      inicio   <= 1'b0;
      done     <= '0;
      rst_ctrl <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (venc_ok) begin
            grant  <= venc_oh;
            x_out  <= op_venc;
            idx    <= venc_idx;
            inicio <= 1'b1;
          end
        end
        INICIA: cnt <= '0;
        ESPERA: begin
          if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
          if (pronto) begin
            result_out <= result_in;
            erro       <= 1'b0;
            done       <= grant;
            rst_ctrl   <= 1'b1;
          end else if (expirou) begin
            result_out <= '0;
            erro       <= 1'b1;
            done       <= grant;
            rst_ctrl   <= 1'b1;
          end
        end
        ENTREGA: begin
          grant  <= '0;
          erro   <= 1'b0;
          ultimo <= idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_calculo.sv
// Self-checking bench for arbitro_calculo: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-timeline reference model.
module tb_arbitro_calculo;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 31;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] op_x = '0;
  logic [N-1:0]   grant, done;
  logic [W-1:0]   result_out, x_out;
  logic [W-1:0]   result_in = '0;
  logic           erro, inicio, rst_ctrl, busy;
  logic           pronto = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int           req_mode;
  logic [N-1:0] fixed_req;
  bit           op_rand;
  logic [N*W-1:0] op_fixed;
  int           d_fixed;
  int           res_fixed;
  bit           stale_force, stale_rand;

  bit ctl_on;
  int ctl_start, ctl_d;
  int cur_d;
  logic [W-1:0] cur_res;

  bit txn, m_err;
  int m_g, m_e, m_w, m_ultimo, m_d;
  logic [W-1:0] m_op, m_val, m_last_x, m_last_res;

  logic [N-1:0] e_grant, e_done;
  logic [W-1:0] e_res, e_x;
  logic e_erro, e_inicio, e_rstc, e_busy;

  int done_log[$];
  int done_cyc[$];
  logic [W-1:0] done_res[$];
  bit done_err[$];

  arbitro_calculo #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .op_x       (op_x),
    .grant      (grant),
    .done       (done),
    .result_out (result_out),
    .erro       (erro),
    .x_out      (x_out),
    .inicio     (inicio),
    .pronto     (pronto),
    .result_in  (result_in),
    .rst_ctrl   (rst_ctrl),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rrPick(input logic [N-1:0] r, input int last);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (((r >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic resetModel();
    txn = 0; m_ultimo = N - 1; m_last_x = '0; m_last_res = '0; ctl_on = 0;
    e_grant = '0; e_done = '0; e_res = '0; e_x = '0;
    e_erro = 0; e_inicio = 0; e_rstc = 0; e_busy = 0;
  endtask

  task automatic checkAll(input string p);
    checkOutput({p, "grant"},    64'(grant),      64'(e_grant));
    checkOutput({p, "done"},     64'(done),       64'(e_done));
    checkOutput({p, "result"},   64'(result_out), 64'(e_res));
    checkOutput({p, "erro"},     64'(erro),       64'(e_erro));
    checkOutput({p, "x_out"},    64'(x_out),      64'(e_x));
    checkOutput({p, "inicio"},   64'(inicio),     64'(e_inicio));
    checkOutput({p, "rst_ctrl"}, 64'(rst_ctrl),   64'(e_rstc));
    checkOutput({p, "busy"},     64'(busy),       64'(e_busy));
  endtask

  // Drive the inputs for the current cycle.
  task automatic applyStimulus();
    bit stale;
    if (req_mode == 1) req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
    else               req = fixed_req;
    op_x  = op_rand ? (N*W)'({$urandom(), $urandom()}) : op_fixed;
    stale = stale_force || (stale_rand && !e_busy && req == '0 && $urandom_range(0, 3) == 0);
    pronto = (ctl_on && cyc >= ctl_start + ctl_d) || stale;
    result_in = pronto ? cur_res : W'($urandom);
  endtask

  // Predict what the next edge does, as a timeline per operation.
  task automatic modelStep();
    int c = cyc + 1;
    if (txn && c - 1 > m_e) begin
      m_ultimo = m_w;
      txn = 0;
    end
    if (!txn && req != '0) begin
      m_w = rrPick(req, m_ultimo);
      m_g = c;
      m_op = W'(op_x >> (m_w * W));
      cur_d = (d_fixed >= 0) ? d_fixed :
              (($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 36)) : int'($urandom_range(1, 10)));
      cur_res = (res_fixed >= 0) ? W'(res_fixed) : W'($urandom);
      m_d = cur_d;
      if (m_d <= TO) begin m_e = m_g + m_d + 1;  m_val = cur_res; m_err = 0; end
      else           begin m_e = m_g + 1 + TO;   m_val = '0;      m_err = 1; end
      txn = 1;
    end
    if (txn && c >= m_g && c <= m_e) begin
      e_grant  = N'(1) << m_w;
      e_busy   = 1;
      e_x      = m_op;
      m_last_x = m_op;
      e_inicio = (c == m_g);
      e_done   = (c == m_e) ? e_grant : '0;
      e_rstc   = (c == m_e);
      e_erro   = (c == m_e) && m_err;
      if (c == m_e) m_last_res = m_val;
      e_res    = m_last_res;
    end else begin
      e_grant = '0; e_done = '0; e_busy = 0; e_inicio = 0; e_rstc = 0; e_erro = 0;
      e_x = m_last_x; e_res = m_last_res;
    end
  endtask

  task automatic observe();
    int id;
    checkAll("");
    if (done != '0) begin
      id = -1;
      for (int i = 0; i < N; i++) if (done[i]) id = i;
      done_log.push_back(id);
      done_cyc.push_back(cyc);
      done_res.push_back(result_out);
      done_err.push_back(erro);
    end
    if (rst_ctrl) ctl_on = 0;
    if (inicio) begin ctl_on = 1; ctl_start = cyc; ctl_d = cur_d; end
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      applyStimulus();
      modelStep();
      @(posedge clk);
      cyc++;
      #1;
      observe();
    end
  endtask

  task automatic runUntilDone(input int n_done, input int budget);
    int target = done_log.size() + n_done;
    int k = 0;
    while (done_log.size() < target && k < budget) begin
      runCycles(1);
      k++;
    end
    checkOutput("done_wait", 64'(done_log.size() >= target), 64'(1));
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int base, s;

    req_mode = 0; fixed_req = '0; op_rand = 1; op_fixed = '0; d_fixed = -1; res_fixed = -1;
    stale_force = 0; stale_rand = 0; cur_d = 5; cur_res = '0;
    resetModel();

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset_");
    @(negedge clk);
    rst = 1'b1;

    // Fairness from reset: requester 0 has first priority.
    fixed_req = 4'b1111;
    base = done_log.size();
    runUntilDone(5, 400);
    if (done_log.size() >= base + 5)
      for (int i = 0; i < 5; i++) checkOutput("fair_order", 64'(done_log[base+i]), 64'(exp_order[i]));
    fixed_req = '0;
    runCycles(3);

    // Wrap-around after requester 3.
    fixed_req = 4'b1000;
    runUntilDone(1, 100);
    checkOutput("wrap_first3", 64'(done_log[$]), 64'(3));
    fixed_req = 4'b1001;
    base = done_log.size();
    runUntilDone(2, 200);
    if (done_log.size() >= base + 2) begin
      checkOutput("wrap_next0", 64'(done_log[base]), 64'(0));
      checkOutput("wrap_then3", 64'(done_log[base+1]), 64'(3));
    end
    fixed_req = '0;
    runCycles(3);

    // Single request with the standard controller latency.
    op_rand = 0; op_fixed = 64'h1234_5678_0003_9ABC;
    d_fixed = 7; res_fixed = 16'h001C;
    fixed_req = 4'b0010;
    s = cyc;
    runUntilDone(1, 40);
    checkOutput("single_owner",   64'(done_log[$]), 64'(1));
    checkOutput("single_latency", 64'(done_cyc[$]), 64'(s + 9));
    checkOutput("single_result",  64'(done_res[$]), 64'(16'h001C));
    checkOutput("single_erro",    64'(done_err[$]), 64'(0));
    fixed_req = '0; op_rand = 1; res_fixed = -1;
    runCycles(2);

    // Timeout: pronto never comes.
    d_fixed = 40; fixed_req = 4'b0100;
    s = cyc;
    runUntilDone(1, 60);
    checkOutput("tmo_latency", 64'(done_cyc[$]), 64'(s + 2 + TO));
    checkOutput("tmo_erro",    64'(done_err[$]), 64'(1));
    checkOutput("tmo_result",  64'(done_res[$]), 64'(0));
    fixed_req = '0;
    runCycles(3);

    // pronto arriving in the very last waiting cycle still wins.
    d_fixed = TO; fixed_req = 4'b0001;
    runUntilDone(1, 60);
    checkOutput("tie_erro", 64'(done_err[$]), 64'(0));
    fixed_req = '0;
    runCycles(2);
    d_fixed = TO + 1; fixed_req = 4'b0001;
    runUntilDone(1, 60);
    checkOutput("late_erro", 64'(done_err[$]), 64'(1));
    fixed_req = '0;
    runCycles(2);

    // Request dropped while waiting: the operation still completes.
    d_fixed = 12; fixed_req = 4'b0001;
    runCycles(4);
    fixed_req = '0;
    runUntilDone(1, 40);
    checkOutput("drop_owner", 64'(done_log[$]), 64'(0));
    runCycles(2);

    // Stale pronto while idle must not start anything.
    stale_force = 1;
    runCycles(6);
    checkOutput("stale_busy", 64'(busy), 64'(0));
    stale_force = 0;
    runCycles(2);

    // Asynchronous reset in the middle of a wait.
    d_fixed = 20; fixed_req = 4'b0100;
    runCycles(6);
    #3;
    rst = 1'b0; req = '0; pronto = 1'b0;
    #1;
    resetModel();
    checkAll("arst_");
    base = done_log.size();
    @(posedge clk);
    #1;
    checkOutput("arst_no_done", 64'(done), 64'(0));
    checkOutput("arst_busy",    64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    d_fixed = 6; fixed_req = 4'b0011;
    runUntilDone(1, 40);
    checkOutput("arst_prio0", 64'(done_log[$]), 64'(0));
    checkOutput("arst_count", 64'(done_log.size()), 64'(base + 1));
    fixed_req = '0;
    runCycles(3);

    // Randomized traffic.
    req_mode = 1; d_fixed = -1; stale_rand = 1;
    runCycles(3000);
    req_mode = 0; fixed_req = '0; stale_rand = 0;
    runCycles(45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
